// File: rtl/pad_es_pkg.sv
// rtl/pad_es_pkg.sv - shared widths, table geometry and FSM encoding for the pad-to-es LUT
package pad_es_pkg;
    localparam int MXADRB       = 8;
    localparam int MXDATB       = 10;
    localparam int ROMLENGTH    = 192;
    localparam int ME1A_ES_BASE = 512;
    localparam int MXES         = 896;

    typedef enum logic {
        CLEAR = 1'b0,
        LOAD  = 1'b1
    } lut_state_t;
endpackage

// File: rtl/pad_es_lut_ram.sv
// rtl/pad_es_lut_ram.sv - one-write, two-read synchronous RAM, read-first, contents not reset
module pad_es_lut_ram
    import pad_es_pkg::*;
#(
    parameter int AW    = MXADRB,
    parameter int DW    = MXDATB,
    parameter int DEPTH = ROMLENGTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra0,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] q0,
    output logic [DW-1:0] q1
);
    logic [DW-1:0] mem [DEPTH];

    // Reads sample the array before this edge's write lands: old data on collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        q0 <= mem[ra0];
        q1 <= mem[ra1];
    end
endmodule

// File: rtl/pad_es_lut_writer.sv
// rtl/pad_es_lut_writer.sv - run-time loaded GEM pad to CSC eighth-strip LUT with clear, autoinc and readback
// Optional running write checksum output lut_cksum under PAD_ES_LUT_CHECKSUM_EN.
module pad_es_lut_writer
    import pad_es_pkg::*;
#(
    parameter int FALLING_EDGE = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lut_clear,
    input  logic              lut_wr_en,
    input  logic [MXADRB-1:0] lut_wr_adr,
    input  logic [MXDATB-1:0] lut_wr_data,
    input  logic              lut_autoinc_en,
    input  logic [MXADRB-1:0] adr0,
    input  logic [MXADRB-1:0] adr1,
    output logic [MXDATB-1:0] rd0,
    output logic [MXDATB-1:0] rd1,
    input  logic [MXADRB-1:0] lut_rb_adr,
    output logic [MXDATB-1:0] lut_rb_data,
    output logic              lut_busy,
    output logic              lut_ready,
    output logic [MXADRB-1:0] lut_wr_ptr,
    output logic              lut_adr_err,
    output logic              lut_wr_drop
`ifdef PAD_ES_LUT_CHECKSUM_EN
    ,
    output logic [15:0]       lut_cksum
`endif
);
    localparam logic [MXADRB-1:0] LEN  = MXADRB'(ROMLENGTH);
    localparam logic [MXADRB-1:0] LAST = MXADRB'(ROMLENGTH - 1);

    logic clk;
    assign clk = (FALLING_EDGE != 0) ? ~clock : clock;

    lut_state_t           state;
    logic [MXADRB-1:0]    clr_cnt;
    logic [ROMLENGTH-1:0] mask;
    logic [ROMLENGTH-1:0] mask_set;
    logic [MXADRB-1:0]    eff_adr;
    logic                 in_range;
    logic                 wr_ok;
    logic                 clr_we;
    logic                 ram_we;
    logic [MXADRB-1:0]    ram_wa;
    logic [MXDATB-1:0]    ram_wd;
    logic                 rd0_ok;
    logic                 rd1_ok;
    logic                 rb_ok;
    logic [MXDATB-1:0]    q0;
    logic [MXDATB-1:0]    q1;
    logic [MXDATB-1:0]    qb;
    logic [MXDATB-1:0]    qb_unused;

    always_comb begin
        eff_adr  = lut_autoinc_en ? lut_wr_ptr : lut_wr_adr;
        in_range = (eff_adr < LEN);
        wr_ok    = !reset && (state == LOAD) && lut_wr_en && !lut_clear && in_range;
        // lut_busy low while in CLEAR marks the one idle cycle right after reset.
        clr_we   = !reset && (state == CLEAR) && lut_busy && !lut_clear;
        ram_we   = wr_ok | clr_we;
        ram_wa   = clr_we ? clr_cnt : eff_adr;
        ram_wd   = clr_we ? '0 : lut_wr_data;
        mask_set = mask;
        if (wr_ok) begin
            mask_set[eff_adr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            mask        <= '0;
            lut_busy    <= 1'b0;
            lut_ready   <= 1'b0;
            lut_wr_ptr  <= '0;
            lut_adr_err <= 1'b0;
            lut_wr_drop <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    mask       <= '0;
                    lut_ready  <= 1'b0;
                    lut_wr_ptr <= '0;
                    if (lut_clear || !lut_busy) begin
                        lut_busy <= 1'b1;
                        clr_cnt  <= '0;
                    end else if (clr_cnt == LAST) begin
                        state    <= LOAD;
                        lut_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                    if (lut_clear) begin
                        lut_adr_err <= 1'b0;
                        lut_wr_drop <= 1'b0;
                    end else if (lut_wr_en && lut_busy) begin
                        lut_wr_drop <= 1'b1;
                    end
                end
                LOAD: begin
                    if (lut_clear) begin
                        state       <= CLEAR;
                        lut_busy    <= 1'b1;
                        clr_cnt     <= '0;
                        mask        <= '0;
                        lut_ready   <= 1'b0;
                        lut_wr_ptr  <= '0;
                        lut_adr_err <= 1'b0;
                        lut_wr_drop <= 1'b0;
                    end else begin
                        mask      <= mask_set;
                        lut_ready <= &mask_set;
                        if (lut_wr_en && !in_range) begin
                            lut_adr_err <= 1'b1;
                        end
                        // Pointer stops at ROMLENGTH since out-of-range writes are never accepted.
                        if (wr_ok && lut_autoinc_en) begin
                            lut_wr_ptr <= lut_wr_ptr + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd0_ok <= 1'b0;
            rd1_ok <= 1'b0;
            rb_ok  <= 1'b0;
        end else begin
            rd0_ok <= (state == LOAD) && (adr0 < LEN);
            rd1_ok <= (state == LOAD) && (adr1 < LEN);
            rb_ok  <= (state == LOAD) && (lut_rb_adr < LEN);
        end
    end

    assign rd0         = rd0_ok ? q0 : '0;
    assign rd1         = rd1_ok ? q1 : '0;
    assign lut_rb_data = rb_ok ? qb : '0;

`ifdef PAD_ES_LUT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || (state == CLEAR) || lut_clear) begin
            lut_cksum <= '0;
        end else if (wr_ok) begin
            lut_cksum <= lut_cksum + 16'({eff_adr, lut_wr_data});
        end
    end
`endif

    pad_es_lut_ram u_ram_match (
        .clk (clk),
        .we  (ram_we),
        .wa  (ram_wa),
        .wd  (ram_wd),
        .ra0 (adr0),
        .ra1 (adr1),
        .q0  (q0),
        .q1  (q1)
    );

    pad_es_lut_ram u_ram_rb (
        .clk (clk),
        .we  (ram_we),
        .wa  (ram_wa),
        .wd  (ram_wd),
        .ra0 (lut_rb_adr),
        .ra1 (lut_rb_adr),
        .q0  (qb),
        .q1  (qb_unused)
    );
endmodule

// File: tb/tb_pad_es_lut_writer.sv
// tb/tb_pad_es_lut_writer.sv - randomized self-checking bench for pad_es_lut_writer against a table model
module tb_pad_es_lut_writer;
    localparam int LEN = 192;

    logic       clock = 1'b0;
    logic       reset;
    logic       lut_clear;
    logic       lut_wr_en;
    logic [7:0] lut_wr_adr;
    logic [9:0] lut_wr_data;
    logic       lut_autoinc_en;
    logic [7:0] adr0;
    logic [7:0] adr1;
    logic [9:0] rd0;
    logic [9:0] rd1;
    logic [7:0] lut_rb_adr;
    logic [9:0] lut_rb_data;
    logic       lut_busy;
    logic       lut_ready;
    logic [7:0] lut_wr_ptr;
    logic       lut_adr_err;
    logic       lut_wr_drop;
`ifdef PAD_ES_LUT_CHECKSUM_EN
    logic [15:0] lut_cksum;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    int mem_m [LEN];
    bit wr_m  [LEN];
    int ptr_m;
    bit err_m;
    bit drop_m;
    int ck_m;

    always #5 clock = ~clock;

    pad_es_lut_writer #(.FALLING_EDGE(0)) dut (
        .clock          (clock),
        .reset          (reset),
        .lut_clear      (lut_clear),
        .lut_wr_en      (lut_wr_en),
        .lut_wr_adr     (lut_wr_adr),
        .lut_wr_data    (lut_wr_data),
        .lut_autoinc_en (lut_autoinc_en),
        .adr0           (adr0),
        .adr1           (adr1),
        .rd0            (rd0),
        .rd1            (rd1),
        .lut_rb_adr     (lut_rb_adr),
        .lut_rb_data    (lut_rb_data),
        .lut_busy       (lut_busy),
        .lut_ready      (lut_ready),
        .lut_wr_ptr     (lut_wr_ptr),
        .lut_adr_err    (lut_adr_err),
        .lut_wr_drop    (lut_wr_drop)
`ifdef PAD_ES_LUT_CHECKSUM_EN
        ,
        .lut_cksum      (lut_cksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < LEN; i++) begin
            mem_m[i] = 0;
            wr_m[i]  = 1'b0;
        end
        ptr_m  = 0;
        err_m  = 1'b0;
        drop_m = 1'b0;
        ck_m   = 0;
    endtask

    function automatic bit ready_m();
        for (int i = 0; i < LEN; i++) begin
            if (!wr_m[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int exp_rd(input int a);
        return (a < LEN) ? mem_m[a] : 0;
    endfunction

    task automatic wait_clear(input int start, input string tag);
        int n;
        n = start;
        while (lut_busy && n < 1000) begin
            tick();
            n++;
        end
        check(tag, n, LEN);
    endtask

    task automatic pulse_clear();
        lut_clear = 1'b1;
        tick();
        lut_clear = 1'b0;
        model_clear();
        check("busy_on_clear", lut_busy, 1);
    endtask

    task automatic do_write(input bit ai, input logic [7:0] a, input logic [9:0] d);
        int eff;
        lut_autoinc_en = ai;
        lut_wr_adr     = a;
        lut_wr_data    = d;
        lut_wr_en      = 1'b1;
        tick();
        lut_wr_en = 1'b0;
        eff = ai ? ptr_m : int'(a);
        if (eff < LEN) begin
            mem_m[eff] = int'(d);
            wr_m[eff]  = 1'b1;
            ck_m = (ck_m + ((eff << 10) | int'(d))) & 32'hFFFF;
            if (ai) ptr_m++;
        end else begin
            err_m = 1'b1;
        end
        check("wr_adr_err", lut_adr_err, err_m);
        check("wr_ptr", lut_wr_ptr, ptr_m);
        check("wr_ready", lut_ready, ready_m());
`ifdef PAD_ES_LUT_CHECKSUM_EN
        check("wr_cksum", lut_cksum, ck_m);
`endif
    endtask

    task automatic do_read(input int a0, input int a1, input int ab);
        adr0       = 8'(a0);
        adr1       = 8'(a1);
        lut_rb_adr = 8'(ab);
        tick();
        check("rd0", rd0, exp_rd(a0));
        check("rd1", rd1, exp_rd(a1));
        check("rb", lut_rb_data, exp_rd(ab));
    endtask

    task automatic sweep();
        for (int a = 0; a < LEN; a++) begin
            do_read(a, LEN - 1 - a, a);
        end
    endtask

    initial begin
        reset = 1'b1;
        lut_clear = 1'b0;
        lut_wr_en = 1'b0;
        lut_wr_adr = '0;
        lut_wr_data = '0;
        lut_autoinc_en = 1'b0;
        adr0 = 8'd5;
        adr1 = '0;
        lut_rb_adr = '0;
        model_clear();
        tick();
        tick();
        check("rst_busy", lut_busy, 0);
        check("rst_ready", lut_ready, 0);
        check("rst_ptr", lut_wr_ptr, 0);
        check("rst_err", lut_adr_err, 0);
        check("rst_drop", lut_wr_drop, 0);
        check("rst_rd0", rd0, 0);
        check("rst_rb", lut_rb_data, 0);

        reset = 1'b0;
        tick();
        check("busy_after_reset", lut_busy, 1);
        wait_clear(0, "reset_clear_len");
        do_read(5, 200, 10);
        check("ready_after_clear", lut_ready, 0);

        for (int i = 0; i < LEN; i++) begin
            do_write(1'b1, 8'd0, 10'(2 * i + 1));
        end
        do_read(100, 200, 150);
        check("rd0_adr100", rd0, 201);

        do_write(1'b1, 8'd0, 10'd555);
        do_write(1'b0, 8'd192, 10'd77);
        do_read(192, 200, 255);
        sweep();

        repeat (40) do_write(1'b0, 8'($urandom_range(0, LEN - 1)), 10'($urandom_range(0, 1023)));
        repeat (40) do_read($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));

        do_write(1'b0, 8'd7, 10'h00F);
        adr0 = 8'd7;
        do_write(1'b0, 8'd7, 10'h3FF);
        check("coll_old", rd0, 10'h00F);
        tick();
        check("coll_new", rd0, 10'h3FF);

        adr0 = 8'd100;
        pulse_clear();
        tick();
        check("rd_during_clear", rd0, 0);
        tick();
        lut_autoinc_en = 1'b0;
        lut_wr_adr = 8'd3;
        lut_wr_data = 10'h155;
        lut_wr_en = 1'b1;
        tick();
        lut_wr_en = 1'b0;
        drop_m = 1'b1;
        check("drop_set", lut_wr_drop, drop_m);
        check("drop_ready", lut_ready, 0);
        check("drop_err", lut_adr_err, 0);
        wait_clear(3, "clear_len_drop");

        do_write(1'b0, 8'd0, 10'd1);
        do_write(1'b0, 8'd1, 10'd2);
`ifdef PAD_ES_LUT_CHECKSUM_EN
        check("cksum_example", lut_cksum, 16'h0403);
`endif
        for (int i = 0; i < LEN; i++) begin
            do_write(1'b1, 8'd0, 10'($urandom_range(0, 1023)));
        end
        sweep();
        check("drop_sticky", lut_wr_drop, drop_m);

        pulse_clear();
        repeat (50) tick();
        pulse_clear();
        wait_clear(0, "clear_restart_len");
        check("restart_ready", lut_ready, 0);
        repeat (20) do_read($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));

        repeat (30) do_write(1'b1, 8'd0, 10'($urandom_range(0, 1023)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        check("midload_rst_busy", lut_busy, 0);
        check("midload_rst_ptr", lut_wr_ptr, 0);
        tick();
        wait_clear(0, "midload_clear_len");
        for (int a = 0; a < 40; a++) begin
            do_read(a, a + 100, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
